// File: rtl/dsp_shift_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_shift_add_pkg
// Brief    : Default widths and reference shift-add for the shared DSP arbiter.
// Revision : 1.0
// ============================================================================
package dsp_shift_add_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_A_W     = 20;
    localparam int DEF_B_W     = 18;
    localparam int DEF_SH_W    = 6;
    localparam int DEF_Z_W     = 38;
    localparam int DEF_B_SHIFT = 12;

    // z = (a << shift) + (b << B_SHIFT), all unsigned, truncated to Z_W bits
    function automatic logic [DEF_Z_W-1:0] shift_add(
        input logic [DEF_A_W-1:0]  a,
        input logic [DEF_B_W-1:0]  b,
        input logic [DEF_SH_W-1:0] shift
    );
        logic [DEF_Z_W-1:0] a_term;
        logic [DEF_Z_W-1:0] b_term;
        a_term = '0;
        if (int'(shift) < DEF_Z_W) begin
            a_term = DEF_Z_W'(a) << shift;
        end
        b_term = DEF_Z_W'(b) << DEF_B_SHIFT;
        return a_term + b_term;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_shift_add_dp.sv
`default_nettype none
// ============================================================================
// Module   : dsp_shift_add_dp
// Brief    : Combinational shift-add datapath; swappable for a DSP primitive.
// Revision : 1.0
// ============================================================================
module dsp_shift_add_dp
    import dsp_shift_add_pkg::*;
#(
    parameter int A_W     = DEF_A_W,
    parameter int B_W     = DEF_B_W,
    parameter int SH_W    = DEF_SH_W,
    parameter int Z_W     = DEF_Z_W,
    parameter int B_SHIFT = DEF_B_SHIFT
) (
    input  logic [A_W-1:0]  i_a,
    input  logic [B_W-1:0]  i_b,
    input  logic [SH_W-1:0] i_shift,
    output logic [Z_W-1:0]  o_z
);

    logic [Z_W-1:0] a_term;
    logic [Z_W-1:0] b_term;

    // Shifts of Z_W or more push every a bit out of the result
    always_comb begin
        a_term = '0;
        if (int'(i_shift) < Z_W) begin
            a_term = Z_W'(i_a) << i_shift;
        end
        b_term = Z_W'(i_b) << B_SHIFT;
        o_z    = a_term + b_term;
    end

endmodule
`default_nettype wire

// File: rtl/dsp_shift_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dsp_shift_add_arbiter
// Brief    : Round-robin sharing of one shift-add datapath, 2-stage stall pipe.
// Revision : 1.0
// ============================================================================
module dsp_shift_add_arbiter
    import dsp_shift_add_pkg::*;
#(
    parameter int  NREQ    = DEF_NREQ,
    parameter int  A_W     = DEF_A_W,
    parameter int  B_W     = DEF_B_W,
    parameter int  SH_W    = DEF_SH_W,
    parameter int  Z_W     = DEF_Z_W,
    parameter int  B_SHIFT = DEF_B_SHIFT,
    localparam int ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*A_W-1:0]  req_a,
    input  logic [NREQ*B_W-1:0]  req_b,
    input  logic [NREQ*SH_W-1:0] req_shift,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [Z_W-1:0]       res_z,
    output logic [ID_W-1:0]      res_id,
    output logic                 busy
);

    logic [ID_W-1:0] ptr_q,      ptr_d;
    logic            s1_valid_q, s1_valid_d;
    logic [A_W-1:0]  s1_a_q,     s1_a_d;
    logic [B_W-1:0]  s1_b_q,     s1_b_d;
    logic [SH_W-1:0] s1_sh_q,    s1_sh_d;
    logic [ID_W-1:0] s1_id_q,    s1_id_d;
    logic            s2_valid_q, s2_valid_d;
    logic [Z_W-1:0]  s2_z_q,     s2_z_d;
    logic [ID_W-1:0] s2_id_q,    s2_id_d;

    logic            s2_take;
    logic            s1_take;
    logic            grant_found;
    int              grant_idx;
    int              cand;
    logic [ID_W-1:0] grant_id;
    logic            handshake;
    logic [NREQ-1:0] grant_onehot;
    logic [Z_W-1:0]  dp_z;

    assign s2_take = !s2_valid_q || res_ready;
    assign s1_take = !s1_valid_q || s2_take;

    // Search starts just after the last granted requester and wraps
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 0;
        cand        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr_q) + k) % NREQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_id     = ID_W'(grant_idx);
        handshake    = grant_found && s1_take && !clr;
        grant_onehot = handshake ? (NREQ'(1) << grant_idx) : '0;
    end

    // Gated by rst_n so acceptance stops the instant reset asserts
    assign req_ready = grant_onehot & {NREQ{rst_n}};

    always_comb begin
        ptr_d      = ptr_q;
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_sh_d    = s1_sh_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_z_d     = s2_z_q;
        s2_id_d    = s2_id_q;
        if (clr) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            ptr_d      = ID_W'(NREQ - 1);
        end else begin
            if (s2_take) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_z_d  = dp_z;
                    s2_id_d = s1_id_q;
                end
            end
            if (s1_take) begin
                s1_valid_d = handshake;
                if (handshake) begin
                    s1_a_d  = req_a[grant_idx*A_W +: A_W];
                    s1_b_d  = req_b[grant_idx*B_W +: B_W];
                    s1_sh_d = req_shift[grant_idx*SH_W +: SH_W];
                    s1_id_d = grant_id;
                    ptr_d   = grant_id;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= ID_W'(NREQ - 1);
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sh_q    <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_z_q     <= '0;
            s2_id_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_sh_q    <= s1_sh_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_z_q     <= s2_z_d;
            s2_id_q    <= s2_id_d;
        end
    end

    dsp_shift_add_dp #(
        .A_W     (A_W),
        .B_W     (B_W),
        .SH_W    (SH_W),
        .Z_W     (Z_W),
        .B_SHIFT (B_SHIFT)
    ) u_dp (
        .i_a     (s1_a_q),
        .i_b     (s1_b_q),
        .i_shift (s1_sh_q),
        .o_z     (dp_z)
    );

    assign res_valid = s2_valid_q;
    assign res_z     = s2_z_q;
    assign res_id    = s2_id_q;
    assign busy      = s1_valid_q || s2_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_shift_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_shift_add_arbiter
// Brief    : Randomized and directed bench against a behavioural arbiter model.
// Revision : 1.0
// ============================================================================
module tb_dsp_shift_add_arbiter;
    import dsp_shift_add_pkg::*;

    localparam int NREQ = DEF_NREQ;
    localparam int A_W  = DEF_A_W;
    localparam int B_W  = DEF_B_W;
    localparam int SH_W = DEF_SH_W;
    localparam int Z_W  = DEF_Z_W;
    localparam int ID_W = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clr = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*A_W-1:0]  req_a = '0;
    logic [NREQ*B_W-1:0]  req_b = '0;
    logic [NREQ*SH_W-1:0] req_shift = '0;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [Z_W-1:0]       res_z;
    logic [ID_W-1:0]      res_id;
    logic                 busy;

    dsp_shift_add_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_shift (req_shift),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_z     (res_z),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: two result slots, results computed at issue time
    logic           m1_v, m2_v;
    logic [Z_W-1:0] m1_z, m2_z;
    int             m1_id, m2_id;
    int             m_ptr;
    int             exp_grant;
    logic           m_s1t, m_s2t;
    logic [NREQ-1:0] exp_ready;
    int             hs_count  = 0;
    int             delivered = 0;
    int             grant_log[$];

    task automatic m_reset();
        m1_v = 1'b0; m2_v = 1'b0;
        m1_z = '0;   m2_z = '0;
        m1_id = 0;   m2_id = 0;
        m_ptr = NREQ - 1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_reset();
            check("rst_req_ready", 64'(req_ready), 64'd0);
            check("rst_res_valid", 64'(res_valid), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_res_z", 64'(res_z), 64'd0);
            check("rst_res_id", 64'(res_id), 64'd0);
        end else begin
            m_s2t = !m2_v || res_ready;
            m_s1t = !m1_v || m_s2t;
            exp_grant = -1;
            if (m_s1t && !clr) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (exp_grant < 0 && req_valid[(m_ptr + k) % NREQ])
                        exp_grant = (m_ptr + k) % NREQ;
                end
            end
            exp_ready = (exp_grant >= 0) ? (NREQ'(1) << exp_grant) : '0;
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("res_valid", 64'(res_valid), 64'(m2_v));
            check("busy", 64'(busy), 64'(m1_v || m2_v));
            if (m2_v) begin
                check("res_z", 64'(res_z), 64'(m2_z));
                check("res_id", 64'(res_id), 64'(m2_id));
            end
            if (clr) begin
                m1_v = 1'b0;
                m2_v = 1'b0;
                m_ptr = NREQ - 1;
            end else begin
                if (m2_v && res_ready) delivered++;
                if (m_s2t) begin
                    m2_v = m1_v; m2_z = m1_z; m2_id = m1_id;
                end
                if (m_s1t) begin
                    m1_v = (exp_grant >= 0);
                    if (exp_grant >= 0) begin
                        m1_z  = shift_add(req_a[exp_grant*A_W +: A_W],
                                          req_b[exp_grant*B_W +: B_W],
                                          req_shift[exp_grant*SH_W +: SH_W]);
                        m1_id = exp_grant;
                        m_ptr = exp_grant;
                        hs_count++;
                        grant_log.push_back(exp_grant);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                          input logic [SH_W-1:0] sh);
        req_a[i*A_W +: A_W]       = a;
        req_b[i*B_W +: B_W]       = b;
        req_shift[i*SH_W +: SH_W] = sh;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++)
            set_op(i, A_W'($urandom), B_W'($urandom), SH_W'($urandom_range(0, 63)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    int h0, d0;

    initial begin
        // Literal pins on the reference arithmetic
        check("fn_basic", 64'(shift_add(20'd255, 18'd1, 6'd1)), 64'd4606);
        check("fn_sh63", 64'(shift_add(20'hFFFFF, 18'h3FFFF, 6'd63)), 64'd1073737728);
        check("fn_sh18", 64'(shift_add(20'hFFFFF, 18'h3FFFF, 6'd18)), 64'd1073475584);

        repeat (3) step();
        rst_n = 1'b1;
        res_ready = 1'b1;
        step();

        // Single op on requester 2
        set_op(2, 20'd255, 18'd1, 6'd1);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        check("single_lat1_valid", 64'(res_valid), 64'd0);
        check("single_lat1_busy", 64'(busy), 64'd1);
        step();
        check("single_valid", 64'(res_valid), 64'd1);
        check("single_z", 64'(res_z), 64'd4606);
        check("single_id", 64'(res_id), 64'd2);
        step();
        check("single_busy_end", 64'(busy), 64'd0);

        // Boundary shifts on requester 0, back to back
        set_op(0, 20'hFFFFF, 18'h3FFFF, 6'd63);
        req_valid = 4'b0001;
        step();
        set_op(0, 20'hFFFFF, 18'h3FFFF, 6'd18);
        step();
        req_valid = '0;
        check("bound63_z", 64'(res_z), 64'd1073737728);
        step();
        check("bound18_z", 64'(res_z), 64'd1073475584);
        repeat (2) step();

        // Fairness with all requesters valid
        clr = 1'b1;
        step();
        clr = 1'b0;
        req_valid = '1;
        rand_ops();
        grant_log.delete();
        repeat (12) begin
            step();
            rand_ops();
        end
        check("fair_count", 64'(grant_log.size()), 64'd12);
        for (int i = 0; i < 12 && i < grant_log.size(); i++)
            check("fair_order", 64'(grant_log[i]), 64'(i % NREQ));
        req_valid = '0;
        repeat (3) step();

        // Backpressure
        res_ready = 1'b0;
        req_valid = '1;
        h0 = hs_count;
        repeat (5) begin
            step();
            rand_ops();
        end
        check("bp_accepted", 64'(hs_count - h0), 64'd2);
        check("bp_ready_low", 64'(req_ready), 64'd0);
        d0 = delivered;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (4) step();
        check("bp_drained", 64'(delivered - d0), 64'd2);

        // clr with both stages full
        req_valid = '1;
        repeat (3) begin
            step();
            rand_ops();
        end
        h0 = hs_count;
        clr = 1'b1;
        step();
        check("clr_res_valid", 64'(res_valid), 64'd0);
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_no_hs", 64'(hs_count - h0), 64'd0);
        clr = 1'b0;
        req_valid = 4'b1100;
        grant_log.delete();
        step();
        check("clr_next_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd2);
        req_valid = '0;
        repeat (3) step();

        // Asynchronous reset mid-stream
        req_valid = '1;
        repeat (3) begin
            step();
            rand_ops();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_res_valid", 64'(res_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_req_ready", 64'(req_ready), 64'd0);
        #9;
        rst_n = 1'b1;
        grant_log.delete();
        step();
        check("arst_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);
        repeat (4) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // Random traffic
        repeat (400) begin
            req_valid = NREQ'($urandom);
            res_ready = ($urandom_range(0, 9) < 7);
            clr       = ($urandom_range(0, 99) < 3);
            rand_ops();
            step();
        end
        clr = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (4) step();
        check("final_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
